kv_cache_wr_pack: RTL
=====================

Name: kv_cache_wr_pack

Overview:
- Upstream feeder for the KV-cache packet array. Accepts a per-token stream of K/V elements over a valid/ready handshake and packs MAC_MULT_NUM elements into one cache wordline.
- Issues the wordline as a single-cycle write (address, write-enable, data, byte flag) to the KV-cache packet.
- Owns per-packet deep-sleep control: wakes only the target user's packet, holds input off for the wake-up latency, and re-sleeps the packet when the token is done.

Parameters:
- IDATA_WIDTH, 8: width of one K/V element.
- MAC_MULT_NUM, 8: elements per wordline; also CACHE_NUM, the macros per packet.
- CACHE_PKT_NUM, 2: number of cache packets; user_id[1] selects the packet.
- CACHE_DEPTH, 256: wordlines per macro.
- CACHE_ADDR_WIDTH, $clog2(MAC_MULT_NUM)+$clog2(CACHE_DEPTH): cache address width.
- WAKE_CYCLES, 4: cycles from deepslp deassert to first legal access.

Ports:
- clk  in  1  clock, single domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a token write; honoured only in IDLE.
- user_id  in  2  user for this token; packet = user_id[1].
- base_addr  in  CACHE_ADDR_WIDTH  first wordline address; latched on start.
- in_valid  in  1  element valid.
- in_ready  out  1  element accepted when in_valid & in_ready.
- in_data  in  IDATA_WIDTH  element.
- in_last  in  1  last element of the token; qualified by the handshake.
- cache_addr  out  CACHE_ADDR_WIDTH  write address.
- cache_wen  out  1  one-cycle write strobe.
- cache_wdata  out  MAC_MULT_NUM*IDATA_WIDTH  packed wordline.
- cache_wdata_byte_flag  out  1  0 = full wordline, 1 = partial (final) wordline.
- deepslp  out  CACHE_PKT_NUM*CACHE_NUM  per-macro deep sleep; packet p occupies bits [p*CACHE_NUM +: CACHE_NUM].
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse after the token's final write.

Behaviour:
- Reset values: in_ready=0, cache_wen=0, cache_addr=0, cache_wdata=0, byte_flag=0, busy=0, done=0, deepslp=all ones, lane counter=0, state=IDLE.
- Reset mid-operation: the partial word is discarded and no write is issued.
- All outputs are registered.
- FSM states: IDLE, WAKE, PACK, DONE.
- IDLE:
  - All deepslp bits are 1.
  - On start: latch pkt=user_id[1] and addr=base_addr, clear that packet's deepslp slice, load the wake counter with WAKE_CYCLES-1, go to WAKE.
  - start in any other state is ignored.
- WAKE:
  - Counter decrements each cycle; in_ready=0.
  - At 0, go to PACK; in_ready rises on the first PACK cycle.
  - Total delay from the start edge to in_ready=1 is WAKE_CYCLES+1 cycles.
- PACK:
  - in_ready=1. Each accepted element goes to lane k at bits [k*IDATA_WIDTH +: IDATA_WIDTH]; k increments.
  - Lane k=MAC_MULT_NUM-1 accepted without in_last: next cycle cache_wen=1, byte_flag=0, cache_addr=addr. Then addr increments, k=0, and the pack register clears.
  - Input is never stalled for a write: an element may be accepted in the same cycle a write is presented.
  - in_last accepted (any k): next cycle one write, byte_flag=1 if fewer than MAC_MULT_NUM lanes are filled (else 0), unfilled lanes zero. Then go to DONE; in_ready=0 from the cycle after in_last is accepted.
- DONE:
  - done=1 for one cycle; the packet's deepslp slice returns to 1; go to IDLE.
- Addressing:
  - addr wraps modulo 2^CACHE_ADDR_WIDTH with no flag.
  - cache_addr is held between writes; cache_wdata is held until the next write.
- Only the selected packet ever leaves deep sleep; the other packet stays all ones throughout.

Decomposition:
- Shared package: state enum kv_wr_state_e {IDLE, WAKE, PACK, DONE}, and the constants KV_CACHE_PKT_NUM and MAC_MULT_NUM, which are reused by the cache and its bench.
- One sub-module, kv_lane_packer: lane counter, pack register, full/last detect, zero-fill.
- The FSM, wake counter, address counter and deepslp generation stay in the top module.

Test Plan:
- Reset then idle: rst for 5 cycles -> deepslp all ones, cache_wen=0, in_ready=0, busy=0; a start pulse during rst has no effect.
- Wake latency: start with user_id=2, base_addr=0 -> deepslp[15:8]=0, deepslp[7:0]=0xFF, in_ready rises exactly 5 cycles after start (WAKE_CYCLES=4).
- Full packing: 16 elements 0x01..0x10, in_last on the 16th -> writes at addr 0 (wdata 0x0807060504030201, byte_flag=0) and addr 1 (byte_flag=0), then done one cycle later and packet 1 re-sleeps.
- Partial flush: 11 elements from base_addr=10, in_last on the 11th -> addr 10 full write, addr 11 with lanes 0-2 valid, upper 5 bytes zero, byte_flag=1.
- Back-to-back and wrap: continuous in_valid from base_addr=2047 -> cache_addr goes 2047 then 0, in_ready never drops during PACK; a start pulse during PACK is ignored.
- Reset mid-PACK: assert rst after 5 elements -> no cache_wen, deepslp all ones; the next token's writes start at its own base_addr.

Source files
------------

// File: rtl/kv_cache_wr_pack_pkg.sv
// Shared types and constants for the KV-cache write path.
// The cache array and its bench reuse these constants.
package kv_cache_wr_pack_pkg;

  localparam int KV_CACHE_PKT_NUM = 2;
  localparam int MAC_MULT_NUM     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAKE = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } kv_wr_state_e;

endpackage

// File: rtl/kv_cache_wr_pack_lane_packer.sv
// Collects accepted elements into lanes of one wordline and flags when the
// wordline must be written (full, or final element of the token).
module kv_lane_packer #(
  parameter int IDATA_WIDTH = 8,
  parameter int LANES       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         accept_i,
  input  logic [IDATA_WIDTH-1:0]       data_i,
  input  logic                         last_i,
  output logic                         emit_o,
  output logic [LANES*IDATA_WIDTH-1:0] word_o,
  output logic                         partial_o
);

  localparam int KW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [KW-1:0]                  lane_q, lane_d;
  logic [LANES*IDATA_WIDTH-1:0]   pack_q, pack_d;
  logic                           full;

  // The incoming element is merged into its lane combinationally so a write
  // can be presented on the cycle right after the closing element.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign word_o[gi*IDATA_WIDTH +: IDATA_WIDTH] =
      (lane_q == KW'(gi)) ? data_i : pack_q[gi*IDATA_WIDTH +: IDATA_WIDTH];
  end

  assign full      = (lane_q == KW'(LANES - 1));
  assign emit_o    = accept_i && (full || last_i);
  assign partial_o = last_i && !full;

  always_comb begin
    lane_d = lane_q;
    pack_d = pack_q;
    if (accept_i) begin
      if (full || last_i) begin
        // Clearing here is what zero-fills the unused lanes of a short word.
        lane_d = '0;
        pack_d = '0;
      end else begin
        lane_d = lane_q + KW'(1);
        pack_d = word_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      pack_q <= '0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/kv_cache_wr_pack.sv
// KV-cache write packer: wakes the target packet, packs elements into
// wordlines, issues single-cycle writes, then puts the packet back to sleep.
module kv_cache_wr_pack #(
  parameter int IDATA_WIDTH      = 8,
  parameter int MAC_MULT_NUM     = 8,
  parameter int CACHE_PKT_NUM    = 2,
  parameter int CACHE_DEPTH      = 256,
  parameter int CACHE_ADDR_WIDTH = $clog2(MAC_MULT_NUM) + $clog2(CACHE_DEPTH),
  parameter int WAKE_CYCLES      = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [1:0]                             user_id,
  input  logic [CACHE_ADDR_WIDTH-1:0]            base_addr,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [IDATA_WIDTH-1:0]                 in_data,
  input  logic                                   in_last,
  output logic [CACHE_ADDR_WIDTH-1:0]            cache_addr,
  output logic                                   cache_wen,
  output logic [MAC_MULT_NUM*IDATA_WIDTH-1:0]    cache_wdata,
  output logic                                   cache_wdata_byte_flag,
  output logic [CACHE_PKT_NUM*MAC_MULT_NUM-1:0]  deepslp,
  output logic                                   busy,
  output logic                                   done
);

  import kv_cache_wr_pack_pkg::*;

  localparam int CACHE_NUM = MAC_MULT_NUM;
  localparam int WORD_W    = MAC_MULT_NUM * IDATA_WIDTH;
  localparam int DS_W      = CACHE_PKT_NUM * CACHE_NUM;
  localparam int WCW       = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  kv_wr_state_e                state_q, state_d;
  logic [WCW-1:0]              wake_cnt_q, wake_cnt_d;
  logic [CACHE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CACHE_ADDR_WIDTH-1:0] cache_addr_q, cache_addr_d;
  logic [WORD_W-1:0]           wdata_q, wdata_d;
  logic [DS_W-1:0]             deepslp_q, deepslp_d;
  logic                        in_ready_q, in_ready_d;
  logic                        wen_q, wen_d;
  logic                        flag_q, flag_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic                        accept;
  logic                        emit;
  logic                        emit_partial;
  logic [WORD_W-1:0]           emit_word;
  logic                        unused_uid;

  assign unused_uid = user_id[0];
  // in_ready is only ever high while in PACK, so this is the full handshake.
  assign accept     = in_valid && in_ready_q;

  kv_lane_packer #(
    .IDATA_WIDTH (IDATA_WIDTH),
    .LANES       (MAC_MULT_NUM)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .accept_i  (accept),
    .data_i    (in_data),
    .last_i    (in_last),
    .emit_o    (emit),
    .word_o    (emit_word),
    .partial_o (emit_partial)
  );

  always_comb begin
    state_d      = state_q;
    wake_cnt_d   = wake_cnt_q;
    addr_d       = addr_q;
    cache_addr_d = cache_addr_q;
    wdata_d      = wdata_q;
    flag_d       = flag_q;
    deepslp_d    = deepslp_q;
    in_ready_d   = 1'b0;
    wen_d        = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          wake_cnt_d = WCW'(WAKE_CYCLES - 1);
          for (int p = 0; p < CACHE_PKT_NUM; p++) begin
            if (p == int'(user_id[1])) deepslp_d[p*CACHE_NUM +: CACHE_NUM] = '0;
          end
          state_d = WAKE;
        end
      end
      WAKE: begin
        if (wake_cnt_q == '0) state_d = PACK;
        else                  wake_cnt_d = wake_cnt_q - WCW'(1);
      end
      PACK: begin
        in_ready_d = 1'b1;
        if (emit) begin
          wen_d        = 1'b1;
          cache_addr_d = addr_q;
          wdata_d      = emit_word;
          flag_d       = emit_partial;
          addr_d       = addr_q + CACHE_ADDR_WIDTH'(1);
        end
        if (accept && in_last) begin
          in_ready_d = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        done_d    = 1'b1;
        deepslp_d = '1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wake_cnt_q   <= '0;
      addr_q       <= '0;
      cache_addr_q <= '0;
      wdata_q      <= '0;
      flag_q       <= 1'b0;
      deepslp_q    <= '1;
      in_ready_q   <= 1'b0;
      wen_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wake_cnt_q   <= wake_cnt_d;
      addr_q       <= addr_d;
      cache_addr_q <= cache_addr_d;
      wdata_q      <= wdata_d;
      flag_q       <= flag_d;
      deepslp_q    <= deepslp_d;
      in_ready_q   <= in_ready_d;
      wen_q        <= wen_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign in_ready              = in_ready_q;
  assign cache_addr            = cache_addr_q;
  assign cache_wen             = wen_q;
  assign cache_wdata           = wdata_q;
  assign cache_wdata_byte_flag = flag_q;
  assign deepslp               = deepslp_q;
  assign busy                  = busy_q;
  assign done                  = done_q;

endmodule
